// File: rtl/usb_bit_timer.sv
// Receive-side USB bit timer: regenerates the mid-bit sample strobe from line
// transitions and counts strobes into bytes.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_POINT  = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             d_plus,
  input  logic                             enable,
  output logic                             shift_strobe,
  output logic                             byte_done,
  output logic [$clog2(BITS_PER_BYTE)-1:0] bit_cnt,
  output logic                             sample_bit
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(BITS_PER_BYTE);
  localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [CW-1:0] CNT_LAST     = CW'(BITS_PER_BYTE - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          d_prev_q, d_prev_d;
  logic          sample_bit_q, sample_bit_d;
  logic          edge_det;

  always_comb begin
    edge_det     = (d_plus != d_prev_q);
    shift_strobe = enable && (phase_q == PHASE_SAMPLE);
    byte_done    = shift_strobe && (bit_cnt_q == CNT_LAST);
    d_prev_d     = d_plus;

    // Any line transition re-anchors the bit period; the strobe for the
    // current cycle is still decided from the registered phase.
    if (!enable || edge_det || (phase_q == PHASE_LAST)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PW'(1);
    end

    bit_cnt_d = bit_cnt_q;
    if (!enable) begin
      bit_cnt_d = '0;
    end else if (shift_strobe) begin
      bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);
    end

    sample_bit_d = shift_strobe ? d_plus : sample_bit_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      d_prev_q     <= 1'b1;
      sample_bit_q <= 1'b1;
    end else begin
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      d_prev_q     <= d_prev_d;
      sample_bit_q <= sample_bit_d;
    end
  end

  assign bit_cnt    = bit_cnt_q;
  assign sample_bit = sample_bit_q;

endmodule

// File: tb/tb_usb_bit_timer.sv
// Bench for usb_bit_timer: directed scenarios plus random traffic, checked
// against a model that times strobes from the last re-anchor cycle.
module tb_usb_bit_timer;

  localparam int CPB = 8;
  localparam int SP  = 3;
  localparam int BPB = 8;
  localparam int CW  = $clog2(BPB);

  logic          clk    = 1'b0;
  logic          n_rst  = 1'b0;
  logic          d_plus = 1'b1;
  logic          enable = 1'b0;
  logic          shift_strobe;
  logic          byte_done;
  logic [CW-1:0] bit_cnt;
  logic          sample_bit;

  int checks = 0;
  int errors = 0;

  // Model state: strobe fires when (t - anchor) mod CPB == SP, where anchor is
  // the cycle after the latest edge / disabled cycle / reset release.
  int   t      = 0;
  int   anchor = 0;
  int   m_cnt  = 0;
  logic m_prev = 1'b1;
  logic m_sbit = 1'b1;

  logic [CW+2:0] exp_v;
  logic [CW+2:0] obs;

  always #5 clk = ~clk;

  usb_bit_timer #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_POINT (SP),
    .BITS_PER_BYTE(BPB)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus      (d_plus),
    .enable      (enable),
    .shift_strobe(shift_strobe),
    .byte_done   (byte_done),
    .bit_cnt     (bit_cnt),
    .sample_bit  (sample_bit)
  );

  task automatic model_reset();
    m_prev = 1'b1;
    m_cnt  = 0;
    m_sbit = 1'b1;
    anchor = t;
  endtask

  task automatic tick(input logic en, input logic d);
    logic edge_now;
    logic e_strobe;
    logic e_bd;
    @(posedge clk);
    #1;
    enable = en;
    d_plus = d;
    @(negedge clk);
    edge_now = (d != m_prev);
    e_strobe = en && (((t - anchor) % CPB) == SP);
    e_bd     = e_strobe && (m_cnt == BPB - 1);
    exp_v    = {e_strobe, e_bd, CW'(m_cnt), m_sbit};
    obs      = {shift_strobe, byte_done, bit_cnt, sample_bit};
    if (!en) m_cnt = 0;
    else if (e_strobe) m_cnt = (m_cnt + 1) % BPB;
    if (e_strobe) m_sbit = d;
    if (!en || edge_now) anchor = t + 1;
    m_prev = d;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    n_rst  = 1'b0;
    enable = 1'b0;
    d_plus = 1'b1;
    #12;
    checks++;
    if ({shift_strobe, byte_done, bit_cnt, sample_bit} !== {2'b00, CW'(0), 1'b1}) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b",
               {shift_strobe, byte_done, bit_cnt, sample_bit}, {2'b00, CW'(0), 1'b1});
    end
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_steady();
    idle(2);
    for (int i = 0; i <= 60; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL steady_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if ({shift_strobe, byte_done} !== {(i % 8 == 3), (i == 59)}) begin
        errors++;
        $display("FAIL steady_strobe cyc=%0d got=%b exp=%b", i,
                 {shift_strobe, byte_done}, {(i % 8 == 3), (i == 59)});
      end
    end
    checks++;
    if (bit_cnt !== CW'(0)) begin
      errors++;
      $display("FAIL steady_wrap got=%0d exp=0", bit_cnt);
    end
  endtask

  task automatic test_late_edge();
    idle(2);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, (i < 6));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL late_edge_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if (shift_strobe !== (i == 3 || i == 10)) begin
        errors++;
        $display("FAIL late_edge_strobe cyc=%0d got=%b exp=%b", i, shift_strobe, (i == 3 || i == 10));
      end
    end
    checks++;
    if (bit_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL late_edge_cnt got=%0d exp=2", bit_cnt);
    end
  endtask

  task automatic test_edge_at_sample();
    idle(2);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, (i < 3));
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL at_sample_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if (shift_strobe !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL at_sample_strobe cyc=%0d got=%b exp=%b", i, shift_strobe, (i == 3 || i == 7));
      end
      if (i == 4) begin
        checks++;
        if (sample_bit !== 1'b0) begin
          errors++;
          $display("FAIL at_sample_bit got=%b exp=0", sample_bit);
        end
      end
    end
  endtask

  task automatic test_early_edge();
    int n_strobes;
    n_strobes = 0;
    idle(2);
    for (int i = 0; i <= 12; i++) begin
      tick(1'b1, (i < 1));
      if (shift_strobe === 1'b1) n_strobes++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL early_edge_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if (shift_strobe !== (i == 5)) begin
        errors++;
        $display("FAIL early_edge_strobe cyc=%0d got=%b exp=%b", i, shift_strobe, (i == 5));
      end
    end
    checks++;
    if (n_strobes != 1) begin
      errors++;
      $display("FAIL early_edge_count got=%0d exp=1", n_strobes);
    end
  endtask

  task automatic test_enable_drop();
    logic en;
    logic want;
    idle(2);
    for (int i = 0; i < 52; i++) begin
      en   = !(i >= 36 && i < 40);
      want = (i < 36) ? (i % 8 == 3) : (i >= 40) ? ((i - 40) % 8 == 3) : 1'b0;
      tick(en, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL en_drop_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if ({shift_strobe, byte_done} !== {want, 1'b0}) begin
        errors++;
        $display("FAIL en_drop_strobe cyc=%0d got=%b exp=%b", i, {shift_strobe, byte_done}, {want, 1'b0});
      end
      if (i == 37 || i == 40) begin
        checks++;
        if (bit_cnt !== CW'(0)) begin
          errors++;
          $display("FAIL en_drop_cnt cyc=%0d got=%0d exp=0", i, bit_cnt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    idle(2);
    // Line held at K from cycle 0: edge at cycle 0 shifts strobes to 4,12,...
    for (int i = 0; i < 47; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL async_pre_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    checks++;
    if ({bit_cnt, sample_bit} !== {CW'(6), 1'b0}) begin
      errors++;
      $display("FAIL async_pre_state got=%b exp=%b", {bit_cnt, sample_bit}, {CW'(6), 1'b0});
    end
    #3;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({shift_strobe, byte_done, bit_cnt, sample_bit} !== {2'b00, CW'(0), 1'b1}) begin
      errors++;
      $display("FAIL async_reset_values got=%b exp=%b",
               {shift_strobe, byte_done, bit_cnt, sample_bit}, {2'b00, CW'(0), 1'b1});
    end
    enable = 1'b0;
    d_plus = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i <= 60; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL async_post_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if ({shift_strobe, byte_done} !== {(i % 8 == 3), (i == 59)}) begin
        errors++;
        $display("FAIL async_post_strobe cyc=%0d got=%b exp=%b", i,
                 {shift_strobe, byte_done}, {(i % 8 == 3), (i == 59)});
      end
    end
  endtask

  task automatic test_random();
    logic en;
    logic d;
    d = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 5) == 0) d = ~d;
      tick(en, d);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steady();
    test_late_edge();
    test_edge_at_sample();
    test_early_edge();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
